// File: rtl/id_ex_pipe_if.sv
// id_ex_pipe_if: decode-side inputs, EX-side register outputs and hazard controls of the ID/EX boundary.
interface id_ex_pipe_if #(parameter int XLEN = 32);
    logic            id_valid;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic            id_uses_rs2;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_pc;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            id_mem_to_reg;
    logic            id_alu_src;
    logic            id_branch;
    logic [3:0]      id_alu_op;
    logic            flush;
    logic            ex_hold;
    logic            ex_valid;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_pc;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_mem_to_reg;
    logic            ex_alu_src;
    logic            ex_branch;
    logic [3:0]      ex_alu_op;
    logic            pc_write;
    logic            if_id_write;
    logic            load_use_stall;
    logic [15:0]     stall_cycles;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_uses_rs2,
               id_rs1_data, id_rs2_data, id_imm, id_pc,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch,
               id_alu_op, flush, ex_hold,
        input  ex_valid, ex_rs1, ex_rs2, ex_rd,
               ex_rs1_data, ex_rs2_data, ex_imm, ex_pc,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch,
               ex_alu_op, pc_write, if_id_write, load_use_stall, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_uses_rs2,
               id_rs1_data, id_rs2_data, id_imm, id_pc,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch,
               id_alu_op, flush, ex_hold,
        output ex_valid, ex_rs1, ex_rs2, ex_rd,
               ex_rs1_data, ex_rs2_data, ex_imm, ex_pc,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch,
               ex_alu_op, pc_write, if_id_write, load_use_stall, stall_cycles
    );
endinterface

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with load-use hazard detection, flush/hold control
// and a saturating stall-cycle counter.
module id_ex_pipe #(parameter int XLEN = 32) (
    input logic         clk,
    input logic         rst,
    id_ex_pipe_if.slave bus
);
    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic [3:0] alu_op;
    } ctrl_t;

    ctrl_t           ctrl_q, ctrl_d, id_ctrl;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [15:0]     stall_cycles_q, stall_cycles_d;
    logic            hazard, load_use, keep_data;

    // Only a valid load with a non-zero destination can starve a dependent ID instruction.
    assign hazard = ctrl_q.valid & ctrl_q.mem_read & (ctrl_q.rd != 5'd0) & bus.id_valid &
                    ((ctrl_q.rd == bus.id_rs1) | (bus.id_uses_rs2 & (ctrl_q.rd == bus.id_rs2)));
    assign load_use  = hazard & ~bus.ex_hold & ~bus.flush;
    assign keep_data = bus.ex_hold & ~bus.flush;

    always_comb begin
        id_ctrl = {bus.id_valid, bus.id_rs1, bus.id_rs2, bus.id_rd,
                   {6{bus.id_valid}} & {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write,
                                        bus.id_mem_to_reg, bus.id_alu_src, bus.id_branch},
                   bus.id_alu_op};
        ctrl_d = (bus.flush | load_use) ? '0 : bus.ex_hold ? ctrl_q : id_ctrl;
        rs1_data_d = keep_data ? rs1_data_q : bus.id_rs1_data;
        rs2_data_d = keep_data ? rs2_data_q : bus.id_rs2_data;
        imm_d = keep_data ? imm_q : bus.id_imm;
        pc_d = keep_data ? pc_q : bus.id_pc;
        stall_cycles_d = ((bus.ex_hold | load_use) & ~bus.flush & (stall_cycles_q != 16'hFFFF))
                         ? stall_cycles_q + 16'd1 : stall_cycles_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q <= '0;
            pc_q <= '0;
            stall_cycles_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q <= imm_d;
            pc_q <= pc_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.ex_valid       = ctrl_q.valid;
    assign bus.ex_rs1         = ctrl_q.rs1;
    assign bus.ex_rs2         = ctrl_q.rs2;
    assign bus.ex_rd          = ctrl_q.rd;
    assign bus.ex_reg_write   = ctrl_q.reg_write;
    assign bus.ex_mem_read    = ctrl_q.mem_read;
    assign bus.ex_mem_write   = ctrl_q.mem_write;
    assign bus.ex_mem_to_reg  = ctrl_q.mem_to_reg;
    assign bus.ex_alu_src     = ctrl_q.alu_src;
    assign bus.ex_branch      = ctrl_q.branch;
    assign bus.ex_alu_op      = ctrl_q.alu_op;
    assign bus.ex_rs1_data    = rs1_data_q;
    assign bus.ex_rs2_data    = rs2_data_q;
    assign bus.ex_imm         = imm_q;
    assign bus.ex_pc          = pc_q;
    assign bus.stall_cycles   = stall_cycles_q;
    assign bus.load_use_stall = load_use;
    assign bus.pc_write       = ~(bus.ex_hold | load_use) | bus.flush;
    assign bus.if_id_write    = ~(bus.ex_hold | load_use) | bus.flush;
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed literal checks plus randomized traffic compared every cycle
// against a behavioural model of the ID/EX register.
module tb_id_ex_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_ex_pipe_if #(.XLEN(32)) bus ();
    id_ex_pipe #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic        m_valid;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [5:0]  m_ctl;
    logic [3:0]  m_alu;
    logic [31:0] m_rs1_data, m_rs2_data, m_imm, m_pc;
    int          m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_hazard();
        return m_valid && m_ctl[4] && m_rd != 5'd0 && bus.id_valid &&
               (m_rd == bus.id_rs1 || (bus.id_uses_rs2 && m_rd == bus.id_rs2)) &&
               !bus.ex_hold && !bus.flush;
    endfunction

    function automatic logic [5:0] id_ctl();
        return {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write,
                bus.id_mem_to_reg, bus.id_alu_src, bus.id_branch};
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit hz;
        if (rst) begin
            m_valid <= 1'b0; m_rs1 <= '0; m_rs2 <= '0; m_rd <= '0; m_ctl <= '0; m_alu <= '0;
            m_rs1_data <= '0; m_rs2_data <= '0; m_imm <= '0; m_pc <= '0; m_cnt <= 0;
        end else begin
            hz = m_hazard();
            if (bus.flush || hz) begin
                m_valid <= 1'b0; m_rs1 <= '0; m_rs2 <= '0; m_rd <= '0; m_ctl <= '0; m_alu <= '0;
            end else if (!bus.ex_hold) begin
                m_valid <= bus.id_valid;
                m_rs1 <= bus.id_rs1; m_rs2 <= bus.id_rs2; m_rd <= bus.id_rd;
                m_ctl <= bus.id_valid ? id_ctl() : 6'd0;
                m_alu <= bus.id_alu_op;
                m_rs1_data <= bus.id_rs1_data; m_rs2_data <= bus.id_rs2_data;
                m_imm <= bus.id_imm; m_pc <= bus.id_pc;
            end
            if ((bus.ex_hold || hz) && !bus.flush && m_cnt < 65535) m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("load_use_stall", bus.load_use_stall, m_hazard());
            chk("pc_write", bus.pc_write, !(bus.ex_hold || m_hazard()) || bus.flush);
            chk("if_id_write", bus.if_id_write, !(bus.ex_hold || m_hazard()) || bus.flush);
            chk("ex_valid", bus.ex_valid, m_valid);
            chk("ex_regnums_aluop", {bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_alu_op},
                {m_rs1, m_rs2, m_rd, m_alu});
            chk("ex_controls", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                                bus.ex_mem_to_reg, bus.ex_alu_src, bus.ex_branch}, m_ctl);
            chk("stall_cycles", bus.stall_cycles, m_cnt);
            if (m_valid) begin
                chk("ex_rs1_data", bus.ex_rs1_data, m_rs1_data);
                chk("ex_rs2_data", bus.ex_rs2_data, m_rs2_data);
                chk("ex_imm", bus.ex_imm, m_imm);
                chk("ex_pc", bus.ex_pc, m_pc);
            end
        end
    end

    task automatic idle();
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0; bus.id_uses_rs2 = 0;
        bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0; bus.id_pc = 0;
        bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
        bus.id_mem_to_reg = 0; bus.id_alu_src = 0; bus.id_branch = 0; bus.id_alu_op = 0;
        bus.flush = 0; bus.ex_hold = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        bus.ex_hold = 1;
        #2;
        chk("reset ex_valid", bus.ex_valid, 0);
        chk("reset stall_cycles", bus.stall_cycles, 0);
        chk("reset pc_write with hold", bus.pc_write, 0);
        chk("reset load_use_stall", bus.load_use_stall, 0);
        bus.ex_hold = 0;
        #1;
        chk("reset pc_write", bus.pc_write, 1);
        #10 rst = 0;
        tick();
        // normal flow
        bus.id_valid = 1; bus.id_rd = 5; bus.id_reg_write = 1; bus.id_imm = 32'h10;
        tick();
        chk("normal ex_rd", bus.ex_rd, 5);
        chk("normal ex_reg_write", bus.ex_reg_write, 1);
        chk("normal ex_imm", bus.ex_imm, 32'h10);
        chk("normal ex_valid", bus.ex_valid, 1);
        // load-use: lw x3 then add x4,x3,x1
        idle();
        bus.id_valid = 1; bus.id_rd = 3; bus.id_rs1 = 2; bus.id_mem_read = 1; bus.id_reg_write = 1;
        tick();
        idle();
        bus.id_valid = 1; bus.id_rd = 4; bus.id_rs1 = 3; bus.id_rs2 = 1; bus.id_uses_rs2 = 1;
        bus.id_reg_write = 1;
        #1;
        chk("lu stall", bus.load_use_stall, 1);
        chk("lu pc_write", bus.pc_write, 0);
        tick();
        chk("lu bubble ex_valid", bus.ex_valid, 0);
        chk("lu bubble ex_mem_read", bus.ex_mem_read, 0);
        chk("lu stall_cycles", bus.stall_cycles, 1);
        chk("lu stall released", bus.load_use_stall, 0);
        tick();
        chk("lu dep ex_rs1", bus.ex_rs1, 3);
        chk("lu dep ex_valid", bus.ex_valid, 1);
        chk("lu dep stall_cycles", bus.stall_cycles, 1);
        // no false stall
        idle();
        bus.id_valid = 1; bus.id_rd = 0; bus.id_mem_read = 1;
        tick();
        idle();
        bus.id_valid = 1; bus.id_rs1 = 0;
        #1;
        chk("x0 no stall", bus.load_use_stall, 0);
        idle();
        bus.id_valid = 1; bus.id_rd = 3; bus.id_mem_read = 1;
        tick();
        idle();
        bus.id_valid = 1; bus.id_rs1 = 7; bus.id_rs2 = 3; bus.id_uses_rs2 = 0;
        #1;
        chk("unused rs2 no stall", bus.load_use_stall, 0);
        bus.id_uses_rs2 = 1;
        #1;
        chk("rs2 stall", bus.load_use_stall, 1);
        bus.flush = 1;
        #1;
        chk("flush kills stall", bus.load_use_stall, 0);
        chk("flush pc_write", bus.pc_write, 1);
        tick();
        chk("flush ex_valid", bus.ex_valid, 0);
        chk("flush stall_cycles", bus.stall_cycles, 1);
        // hold
        idle();
        bus.id_valid = 1; bus.id_rd = 9; bus.id_imm = 32'h55; bus.id_reg_write = 1;
        tick();
        bus.ex_hold = 1;
        for (int i = 0; i < 3; i++) begin
            bus.id_rd = 5'(10 + i); bus.id_imm = 32'h100 + i;
            #1;
            chk("hold pc_write", bus.pc_write, 0);
            tick();
        end
        chk("hold ex_rd", bus.ex_rd, 9);
        chk("hold ex_imm", bus.ex_imm, 32'h55);
        chk("hold stall_cycles", bus.stall_cycles, 4);
        repeat (65531) tick();
        chk("sat reach", bus.stall_cycles, 16'hFFFF);
        repeat (5) tick();
        chk("sat no wrap", bus.stall_cycles, 16'hFFFF);
        // async reset mid-cycle, then reset during hold
        idle();
        bus.id_valid = 1; bus.id_rd = 6; bus.id_reg_write = 1;
        tick();
        chk("pre-reset ex_valid", bus.ex_valid, 1);
        #1 rst = 1;
        #1;
        chk("async ex_valid", bus.ex_valid, 0);
        chk("async stall_cycles", bus.stall_cycles, 0);
        bus.ex_hold = 1;
        bus.id_rd = 12;
        #1 rst = 0;
        bus.ex_hold = 0;
        tick();
        chk("post-reset load ex_valid", bus.ex_valid, 1);
        chk("post-reset load ex_rd", bus.ex_rd, 12);
        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            bus.id_valid = ($urandom_range(0, 9) != 0);
            bus.id_rs1 = 5'($urandom_range(0, 3));
            bus.id_rs2 = 5'($urandom_range(0, 3));
            bus.id_rd = 5'($urandom_range(0, 3));
            bus.id_uses_rs2 = 1'($urandom);
            bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom;
            bus.id_imm = $urandom; bus.id_pc = $urandom;
            bus.id_reg_write = 1'($urandom); bus.id_mem_read = 1'($urandom);
            bus.id_mem_write = 1'($urandom); bus.id_mem_to_reg = 1'($urandom);
            bus.id_alu_src = 1'($urandom); bus.id_branch = 1'($urandom);
            bus.id_alu_op = 4'($urandom);
            bus.flush = ($urandom_range(0, 9) == 0);
            bus.ex_hold = ($urandom_range(0, 6) == 0);
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
